// File: rtl/lcd_hd44780_writer.sv
// HD44780 8-bit write-only driver: power-up init, then periodic "HDU.d°C" frames.
// Optional leading-zero blanking of H/T when LCD_LZB_EN is defined.
module lcd_hd44780_writer #(
  parameter int POWERUP_CYC  = 750000,
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int REFRESH_CYC  = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       centena,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  input  logic [3:0] decimos,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = imax(imax(POWERUP_CYC, REFRESH_CYC),
                             imax(imax(E_PULSE_CYC, CMD_WAIT_CYC),
                                  CLR_WAIT_CYC));
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PWR_END  = CW'(POWERUP_CYC);
  localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT_CYC - 1);
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYC - 1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    SNAP,
    WRITE,
    REFRESH_WAIT
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } phase_t;

  state_t        state;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [2:0]    nxt;
  logic          snap_c;
  logic [3:0]    snap_t;
  logic [3:0]    snap_u;
  logic [3:0]    snap_d;
  logic [CW-1:0] wait_last;
  logic          last_byte;

  function automatic logic [7:0] enc(logic [3:0] v);
    return (v > 4'd9) ? 8'h3F : (8'h30 + {4'h0, v});
  endfunction

  function automatic logic [7:0] init_byte(logic [1:0] i);
    logic [7:0] b;
    unique case (i)
      2'd0: b = 8'h38;
      2'd1: b = 8'h0C;
      2'd2: b = 8'h06;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] hundreds(logic c);
`ifdef LCD_LZB_EN
    return c ? 8'h31 : 8'h20;
`else
    return c ? 8'h31 : 8'h30;
`endif
  endfunction

  function automatic logic [7:0] tens(logic c, logic [3:0] t);
`ifdef LCD_LZB_EN
    return (!c && t == 4'd0) ? 8'h20 : enc(t);
`else
    return enc(t);
`endif
  endfunction

  function automatic logic [7:0] write_byte(
    logic [2:0] i, logic c, logic [3:0] t,
    logic [3:0] u, logic [3:0] d
  );
    logic [7:0] b;
    unique case (i)
      3'd0: b = 8'h80;
      3'd1: b = hundreds(c);
      3'd2: b = tens(c, t);
      3'd3: b = enc(u);
      3'd4: b = 8'h2E;
      3'd5: b = enc(d);
      3'd6: b = 8'hDF;
      default: b = 8'h43;
    endcase
    return b;
  endfunction

  assign lcd_rw = 1'b0;
  assign nxt = idx + 3'd1;

  // Only the clear command needs the long settle time
  assign wait_last = (state == INIT && idx == 3'd3) ? CLR_LAST : CMD_LAST;
  assign last_byte = (state == INIT) ? (idx == 3'd3) : (idx == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= PWR_WAIT;
      phase      <= PH_SETUP;
      cnt        <= '0;
      idx        <= '0;
      snap_c     <= 1'b0;
      snap_t     <= '0;
      snap_u     <= '0;
      snap_d     <= '0;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        PWR_WAIT: begin
          if (cnt == PWR_END) begin
            state    <= INIT;
            phase    <= PH_SETUP;
            idx      <= '0;
            cnt      <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= init_byte(2'd0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        INIT, WRITE: begin
          unique case (phase)
            PH_SETUP: begin
              phase <= PH_PULSE;
              lcd_e <= 1'b1;
              cnt   <= '0;
            end
            PH_PULSE: begin
              if (cnt == E_LAST) begin
                lcd_e <= 1'b0;
                phase <= PH_WAIT;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            default: begin
              if (cnt == wait_last) begin
                cnt <= '0;
                if (last_byte) begin
                  if (state == INIT) begin
                    state     <= SNAP;
                    init_done <= 1'b1;
                  end else begin
                    state      <= REFRESH_WAIT;
                    frame_done <= 1'b1;
                  end
                end else begin
                  idx   <= nxt;
                  phase <= PH_SETUP;
                  if (state == INIT) begin
                    lcd_rs   <= 1'b0;
                    lcd_data <= init_byte(nxt[1:0]);
                  end else begin
                    lcd_rs   <= 1'b1;
                    lcd_data <= write_byte(nxt, snap_c, snap_t,
                                           snap_u, snap_d);
                  end
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          endcase
        end
        SNAP: begin
          snap_c   <= centena;
          snap_t   <= dezena;
          snap_u   <= unidade;
          snap_d   <= decimos;
          state    <= WRITE;
          phase    <= PH_SETUP;
          idx      <= '0;
          cnt      <= '0;
          lcd_rs   <= 1'b0;
          lcd_data <= 8'h80;
        end
        default: begin
          if (cnt == REF_LAST) begin
            state <= SNAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Directed bench for lcd_hd44780_writer with shortened timing parameters.
// Expected frames follow LCD_LZB_EN when the bench is built with it.
module tb_lcd_hd44780_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       centena = 1'b0;
  logic [3:0] dezena = '0;
  logic [3:0] unidade = '0;
  logic [3:0] decimos = '0;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;
  logic       init_done;
  logic       frame_done;

  lcd_hd44780_writer #(
    .POWERUP_CYC (20),
    .E_PULSE_CYC (2),
    .CMD_WAIT_CYC(5),
    .CLR_WAIT_CYC(10),
    .REFRESH_CYC (50)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .centena   (centena),
    .dezena    (dezena),
    .unidade   (unidade),
    .decimos   (decimos),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int rise_cyc = 0;
  int last_fall_cyc = 0;
  logic prev_e = 1'b0;
  logic pulse_ok = 1'b0;
  logic [8:0] held = '0;
  logic [8:0] q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Byte capture, e-pulse width and bus stability while e is high
  always @(negedge clk) begin
    if (!rst_n) pulse_ok = 1'b0;
    if (frame_done) fd_cnt++;
    if (lcd_e && !prev_e) begin
      q.push_back({lcd_rs, lcd_data});
      held = {lcd_rs, lcd_data};
      rise_cyc = cyc;
      pulse_ok = rst_n;
    end else if (lcd_e && prev_e) begin
      chk("bus_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, held});
    end else if (!lcd_e && prev_e) begin
      last_fall_cyc = cyc;
      if (pulse_ok && rst_n) chk("e_width", cyc - rise_cyc, 2);
    end
    chk("rw_zero", {31'd0, lcd_rw}, 0);
    prev_e = lcd_e;
  end

  task automatic set_in(input logic c, input logic [3:0] t,
                        input logic [3:0] u, input logic [3:0] d);
    centena = c;
    dezena = t;
    unidade = u;
    decimos = d;
  endtask

  task automatic do_init(input string tag);
    int rel;
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    n = 0;
    while (!lcd_e && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_first_e"}, cyc - rel, 22);
    chk({tag, "_idone_lo"}, {31'd0, init_done}, 0);
    n = 0;
    while (!init_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idone"}, {31'd0, init_done}, 1);
    chk({tag, "_idone_lat"}, cyc - last_fall_cyc, 10);
    chk({tag, "_nbytes"}, q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [8:0] b;
      logic [8:0] e;
      logic [31:0] v;
      v = 32'h006_00C_038 >> 0;
      case (i)
        0: e = 9'h038;
        1: e = 9'h00C;
        2: e = 9'h006;
        default: e = 9'h001;
      endcase
      b = (q.size() > 0) ? q.pop_front() : 9'h1FF;
      chk($sformatf("%s_ib%0d", tag, i), {23'd0, b}, {23'd0, e});
    end
    q.delete();
  endtask

  task automatic wait_frame(input string tag);
    int start;
    int n;
    start = fd_cnt;
    n = 0;
    while (fd_cnt == start && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_frame_done"}, fd_cnt - start, 1);
    @(negedge clk);
    chk({tag, "_fd_pulse"}, {31'd0, frame_done}, 0);
  endtask

  task automatic check_frame(input string tag, input logic [55:0] exp);
    logic [8:0] b;
    logic [8:0] e;
    chk({tag, "_len"}, q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      e = (i == 0) ? 9'h080 : {1'b1, exp[55-8*(i-1) -: 8]};
      b = (q.size() > 0) ? q.pop_front() : 9'h1FF;
      chk($sformatf("%s_b%0d", tag, i), {23'd0, b}, {23'd0, e});
    end
    q.delete();
  endtask

`ifdef LCD_LZB_EN
  localparam logic [55:0] F1 = 56'h20_32_35_2E_33_DF_43;
  localparam logic [55:0] F2 = 56'h20_20_37_2E_31_DF_43;
  localparam logic [55:0] F4 = 56'h20_39_35_2E_3F_DF_43;
`else
  localparam logic [55:0] F1 = 56'h30_32_35_2E_33_DF_43;
  localparam logic [55:0] F2 = 56'h30_30_37_2E_31_DF_43;
  localparam logic [55:0] F4 = 56'h30_39_35_2E_3F_DF_43;
`endif
  localparam logic [55:0] F5 = 56'h31_30_30_2E_34_DF_43;

  initial begin
    int n;
    set_in(1'b0, 4'd2, 4'd5, 4'd3);
    repeat (3) @(negedge clk);
    chk("rst_e", {31'd0, lcd_e}, 0);
    chk("rst_rs", {31'd0, lcd_rs}, 0);
    chk("rst_data", {24'd0, lcd_data}, 0);
    chk("rst_idone", {31'd0, init_done}, 0);
    chk("rst_fdone", {31'd0, frame_done}, 0);

    do_init("init1");

    wait_frame("f1");
    check_frame("f1", F1);
    set_in(1'b0, 4'd0, 4'd7, 4'd1);

    wait_frame("f2");
    check_frame("f2", F2);
    set_in(1'b0, 4'd2, 4'd5, 4'd3);

    n = 0;
    while (q.size() < 4 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("f3_midwait", q.size(), 4);
    dezena = 4'd9;
    decimos = 4'hA;
    wait_frame("f3");
    check_frame("f3", F1);

    wait_frame("f4");
    check_frame("f4", F4);
    set_in(1'b1, 4'd0, 4'd0, 4'd4);

    wait_frame("f5");
    check_frame("f5", F5);

    n = 0;
    while (!lcd_e && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_e_high", {31'd0, lcd_e}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_e", {31'd0, lcd_e}, 0);
    chk("mid_rst_data", {24'd0, lcd_data}, 0);
    chk("mid_rst_idone", {31'd0, init_done}, 0);
    @(negedge clk);
    q.delete();

    do_init("init2");
    wait_frame("f6");
    check_frame("f6", F5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
